// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcodes, funct codes, FSM states and ALU ops for the multi-cycle MIPS core.
package mips_mc_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int NREG_LOG2_DEF = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_SLT = 6'h2A;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_PASSB} alu_op_e;
endpackage

// File: rtl/mips_mc_alu.sv
// mips_mc_alu: shared combinational ALU; slt is signed, arithmetic wraps.
module mips_mc_alu
  import mips_mc_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] y_o,
  output logic        zero_o
);
  always_comb begin
    y_o = op_i == ALU_ADD ? a_i + b_i :
          op_i == ALU_SUB ? a_i - b_i :
          op_i == ALU_AND ? a_i & b_i :
          op_i == ALU_OR  ? a_i | b_i :
          op_i == ALU_SLT ? {31'd0, $signed(a_i) < $signed(b_i)} : b_i;
    zero_o = y_o == 32'd0;
  end
endmodule

// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS core (FETCH/DECODE/EXEC/MEM/WB) on one shared req/ready word bus.
// Define MIPS_MC_PERF_EN to build the cycle and retired-instruction counters.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          ADDR_W    = 32,
  parameter int          NREG_LOG2 = NREG_LOG2_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_pc,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, alu_q, alu_d, mdr_q, mdr_d;
  logic run_q;
  logic [31:0] regs_q [1<<NREG_LOG2];
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] rs_v, rt_v, sext, b_v, alu_y, addr_sel;
  logic is_r, is_r_alu, is_jr, is_j, is_jal, is_br, is_lw, is_sw, is_exec, alu_zero, take;
  alu_op_e alu_op;
  assign op   = ir_q[31:26];
  assign rs   = ir_q[25:21];
  assign rt   = ir_q[20:16];
  assign rd   = ir_q[15:11];
  assign imm  = ir_q[15:0];
  assign fn   = ir_q[5:0];
  assign rs_v = regs_q[rs];
  assign rt_v = regs_q[rt];
  assign sext = {{16{imm[15]}}, imm};
  assign is_r     = op == OP_RTYPE;
  assign is_r_alu = is_r && (fn == FN_ADDU || fn == FN_SUBU || fn == FN_AND || fn == FN_OR || fn == FN_SLT);
  assign is_jr    = is_r && fn == FN_JR;
  assign is_j     = op == OP_J;
  assign is_jal   = op == OP_JAL;
  assign is_br    = op == OP_BEQ || op == OP_BNE;
  assign is_lw    = op == OP_LW;
  assign is_sw    = op == OP_SW;
  assign is_exec  = is_r_alu || is_br || is_lw || is_sw || op == OP_ORI || op == OP_LUI || op == OP_ADDIU;
  assign alu_op = (is_br || (is_r && fn == FN_SUBU)) ? ALU_SUB :
                  (is_r && fn == FN_AND) ? ALU_AND :
                  (op == OP_ORI || (is_r && fn == FN_OR)) ? ALU_OR :
                  (is_r && fn == FN_SLT) ? ALU_SLT :
                  op == OP_LUI ? ALU_PASSB : ALU_ADD;
  assign b_v = (is_r || is_br) ? rt_v : op == OP_ORI ? {16'd0, imm} : op == OP_LUI ? {imm, 16'd0} : sext;
  assign take = (op == OP_BNE) ^ alu_zero;
  mips_mc_alu u_alu (.a_i(rs_v), .b_i(b_v), .op_i(alu_op), .y_o(alu_y), .zero_o(alu_zero));
  assign mem_addr  = ADDR_W'({addr_sel[31:2], 2'b00});
  assign mem_wdata = rt_v;
  assign wb_pc     = pc_q - 32'd4;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = pc_q;
    wb_valid = 1'b0;
    wb_reg   = is_r ? rd : rt;
    wb_data  = is_lw ? mdr_q : alu_q;
    case (state_q)
      FETCH: begin
        mem_req = run_q;
        if (run_q && mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = is_exec ? EXEC : FETCH;
        if (is_j || is_jal) pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        if (is_jr) pc_d = rs_v;
        if (is_jal) begin
          wb_valid = 1'b1;
          wb_reg   = 5'd31;
          wb_data  = pc_q;
        end
      end
      EXEC: begin
        alu_d   = alu_y;
        state_d = is_br ? FETCH : (is_lw || is_sw) ? MEM : WB;
        if (is_br && take) pc_d = pc_q + {sext[29:0], 2'b00};
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_sw;
        addr_sel = alu_q;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = is_sw ? FETCH : WB;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      run_q   <= 1'b0;
      for (int i = 0; i < (1 << NREG_LOG2); i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      run_q   <= 1'b1;
      if (wb_valid && wb_reg != 5'd0) regs_q[wb_reg] <= wb_data;
    end
  end
`ifdef MIPS_MC_PERF_EN
  logic [31:0] cyc_q, ret_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (state_q != FETCH && state_d == FETCH) ret_q <= ret_q + 32'd1;
    end
  end
  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_mips_mc_core.sv
// tb_mips_mc_core: scoreboarded bench; expected fetches, stores and writebacks are queued up front, a monitor pops them.
module tb_mips_mc_core;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic mem_req, mem_we, wb_valid;
  logic [31:0] mem_addr, mem_wdata, wb_pc, wb_data, cycle_cnt, instret_cnt;
  logic [4:0] wb_reg;
  int checks = 0, failures = 0, cyc = 0, phase = 0, data_delay = 3;
  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  typedef struct packed {logic [31:0] pc; logic [4:0] rg; logic [31:0] d;} wb_t;
  typedef struct packed {logic [31:0] a; logic [31:0] gap;} f_t;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [31:0] waits;} st_t;
  wb_t wb_q[$];
  f_t f_q[$];
  st_t st_q[$];

  always #5 clk = ~clk;

  mips_mc_core dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_reg(wb_reg), .wb_data(wb_data), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (a >= 32'h3000 && a < 32'h3100) return imem[a[7:2]];
    if (a < 32'h40) return dmem[a[5:2]];
    return 32'h0;
  endfunction

  // Memory responder: instruction reads complete at once, data accesses wait data_delay cycles.
  initial begin
    int wc;
    wc = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        mem_rdata = rd_mem(mem_addr);
        mem_ready = (mem_addr < 32'h40) ? (wc >= data_delay) : 1'b1;
        if (mem_ready) begin
          wc = 0;
          if (mem_we && mem_addr < 32'h40) dmem[mem_addr[5:2]] = mem_wdata;
        end else wc++;
      end else begin
        mem_ready = 1'b0;
        wc = 0;
      end
    end
  end

  // Monitor: bus stability, fetch order/timing, stores and writebacks against the queues.
  initial begin
    logic pend;
    logic [64:0] held;
    int last_f, waits;
    f_t fe;
    wb_t we;
    st_t se;
    pend = 1'b0; held = '0; last_f = 0; waits = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (pend && mem_req === 1'b1) chk("bus_stable", {31'd0, held}, {31'd0, mem_we, mem_addr, mem_wdata});
      pend = mem_req === 1'b1 && mem_ready === 1'b0;
      held = {mem_we, mem_addr, mem_wdata};
      if (mem_req === 1'b1 && mem_ready === 1'b1) begin
        if (mem_we) begin
          if (st_q.size() == 0) chk("unexpected_store", {32'd0, mem_addr, mem_wdata}, 96'd0);
          else begin
            se = st_q.pop_front();
            chk("store", {mem_addr, mem_wdata, 32'(waits)}, se);
          end
        end else if (phase == 0 && mem_addr >= 32'h3000 && f_q.size() > 0) begin
          fe = f_q.pop_front();
          chk("fetch_addr", {64'd0, mem_addr}, {64'd0, fe.a});
          if (fe.gap != 0) chk("fetch_gap", 96'(cyc - last_f), {64'd0, fe.gap});
          last_f = cyc;
        end
        waits = 0;
      end else if (mem_req === 1'b1) waits++;
      else waits = 0;
      if (wb_valid === 1'b1) begin
        if (wb_q.size() == 0) chk("unexpected_wb", {wb_pc, wb_data, 27'd0, wb_reg}, 96'd0);
        else begin
          we = wb_q.pop_front();
          chk("wb", {wb_pc, wb_data, 27'd0, wb_reg}, {we.pc, we.d, 27'd0, we.rg});
        end
      end
    end
  end

  initial begin
    logic [31:0] prog [17] = '{
      32'h34011234, 32'h3C02ABCD, 32'h00221821, 32'hAC030008, 32'h0C000C08, 32'h8C040008,
      32'h00210021, 32'h08000C09, 32'h03E00008, 32'h00012821, 32'hFC000000, 32'h14210005,
      32'h00233023, 32'h0061382A, 32'h00624024, 32'h2429FFFC, 32'h1021FFFF};
    logic [31:0] fa [19] = '{
      32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3020, 32'h3014, 32'h3018, 32'h301C,
      32'h3024, 32'h3028, 32'h302C, 32'h3030, 32'h3034, 32'h3038, 32'h303C, 32'h3040, 32'h3040, 32'h3040};
    int fg [19] = '{0, 4, 4, 4, 7, 2, 2, 8, 4, 2, 4, 2, 3, 4, 4, 4, 4, 3, 3};
    wb_t wbs [11] = '{
      '{32'h3000, 5'd1, 32'h00001234}, '{32'h3004, 5'd2, 32'hABCD0000}, '{32'h3008, 5'd3, 32'hABCD1234},
      '{32'h3010, 5'd31, 32'h00003014}, '{32'h3014, 5'd4, 32'hABCD1234}, '{32'h3018, 5'd0, 32'h00002468},
      '{32'h3024, 5'd5, 32'h00001234}, '{32'h3030, 5'd6, 32'h54330000}, '{32'h3034, 5'd7, 32'h00000001},
      '{32'h3038, 5'd8, 32'hABCD0000}, '{32'h303C, 5'd9, 32'h00001230}};
    logic found;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
    // Program layout: jal at 0x3010 jumps to jr at 0x3020, j at 0x301C skips over it to 0x3024.
    for (int i = 0; i < 8; i++) imem[i] = prog[i];
    imem[8] = prog[8];
    for (int i = 9; i < 17; i++) imem[i] = prog[i];
    for (int i = 0; i < 19; i++) f_q.push_back('{fa[i], 32'(fg[i])});
    for (int i = 0; i < 11; i++) wb_q.push_back(wbs[i]);
    st_q.push_back('{32'h8, 32'hABCD1234, 32'd3});
    repeat (3) @(negedge clk);
    chk("reset_bus", {94'd0, mem_req, mem_we}, 96'd0);
    chk("reset_wb", {95'd0, wb_valid}, 96'd0);
    chk("reset_cnt", {32'd0, cycle_cnt, instret_cnt}, 96'd0);
    reset = 1'b0;
    for (int i = 0; i < 600 && (f_q.size() > 0 || wb_q.size() > 0 || st_q.size() > 0); i++) @(negedge clk);
    chk("queues_drained", {32'(f_q.size()), 32'(wb_q.size()), 32'(st_q.size())}, 96'd0);
    // Reset while a lw is stalled in MEM.
    phase = 1;
    imem[0] = 32'h8C040008;
    data_delay = 1000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = mem_req === 1'b1 && mem_addr == 32'h8 && mem_we === 1'b0;
    end
    chk("lw_in_mem", {95'd0, found}, {95'd0, 1'b1});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midlw_req_low", {94'd0, mem_req, wb_valid}, 96'd0);
    chk("midlw_cnt", {32'd0, cycle_cnt, instret_cnt}, 96'd0);
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = mem_req === 1'b1;
    end
    chk("refetch", {63'd0, found, mem_we, mem_addr}, {63'd0, 1'b1, 1'b0, 32'h3000});
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
